// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the input_debounce block.
//   DEF_*       : default parameter values for the top level
//   clog2_min1  : counter width helper that never returns 0
package input_debounce_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_PRESCALE     = 1;
  localparam int unsigned DEF_STABLE_TICKS = 4;

  // Bits needed to hold 0..v-1, at least 1 so a counter always has a real bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    if (v <= 2) begin
      return 1;
    end
    return $clog2(v);
  endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// Single-channel debouncer: synchronizer chain, stability counter, clean level
// and registered rise/fall strobes.
//   clk, rst : clock, asynchronous active-high reset
//   ena      : 0 freezes counter and clean level (synchronizer keeps running)
//   tick     : debounce time base from the shared prescaler
//   raw      : unsynchronized pin level
//   clean    : debounced level
//   rise/fall: one-cycle pulse in the first cycle clean reads 1 / 0
module debounce_bit
  import input_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2_min1(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchronizer runs regardless of ena so it never holds a stale sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  // State is (r_cnt, r_clean): IDLE when w_s matches clean, COUNTING otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (ena) begin
        if (w_s == r_clean) begin
          // Any return to the clean level discards the partial count.
          r_cnt <= '0;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            r_clean <= w_s;
            r_cnt   <= '0;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/input_debounce.sv
// Per-bit input conditioner for the dedicated input bus.
//   clk, rst  : clock, asynchronous active-high reset
//   ena       : design enable; 0 freezes prescaler and debounce state
//   raw_in    : unsynchronized pin levels
//   clean_out : debounced levels
//   rise/fall : one-cycle pulses on clean 0->1 / 1->0
//   changed   : OR of all rise and fall bits in the same cycle
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned PRESCALE     = DEF_PRESCALE,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned PS_W = clog2_min1(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_presc;
  logic            w_tick;

  // With PRESCALE=1 the counter is pinned at 0 and w_tick reduces to ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (ena) begin
      r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  assign w_tick = ena & (r_presc == PS_LAST);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .tick (w_tick),
      .raw  (raw_in[g]),
      .clean(clean_out[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena_d, ena_p;
  logic [7:0] raw_d, raw_p;
  logic [7:0] clean_d, rise_d, fall_d, clean_p, rise_p, fall_p;
  logic       chg_d, chg_p;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_debounce dut (
    .clk(clk), .rst(rst), .ena(ena_d), .raw_in(raw_d),
    .clean_out(clean_d), .rise(rise_d), .fall(fall_d), .changed(chg_d)
  );

  input_debounce #(.PRESCALE(4)) dut_p4 (
    .clk(clk), .rst(rst), .ena(ena_p), .raw_in(raw_p),
    .clean_out(clean_p), .rise(rise_p), .fall(fall_p), .changed(chg_p)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = default DUT, 1 = PRESCALE=4 DUT.
  // Delay line for synchronization, an enabled-cycle count modulo prescale for
  // ticks, and a run length of consecutive disagreeing ticks per bit.
  logic [7:0] m_hist  [2][SYNC];
  int         m_run   [2][8];
  int         m_ecnt  [2];
  logic [7:0] m_clean [2];
  logic [7:0] m_rise  [2];
  logic [7:0] m_fall  [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < SYNC; j++) m_hist[k][j] = '0;
      for (int b = 0; b < 8; b++) m_run[k][b] = 0;
      m_ecnt[k] = 0; m_clean[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input logic en, input logic [7:0] raw, input int pre);
    logic [7:0] s;
    logic       tk;
    s = m_hist[k][SYNC-1];
    for (int j = SYNC - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = raw;
    tk = en && ((m_ecnt[k] % pre) == pre - 1);
    if (en) m_ecnt[k]++;
    m_rise[k] = '0;
    m_fall[k] = '0;
    if (en) begin
      for (int b = 0; b < 8; b++) begin
        if (s[b] == m_clean[k][b]) begin
          m_run[k][b] = 0;
        end else if (tk) begin
          m_run[k][b]++;
          if (m_run[k][b] == STABLE) begin
            m_clean[k][b] = s[b];
            m_rise[k][b]  = s[b];
            m_fall[k][b]  = ~s[b];
            m_run[k][b]   = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else begin
      model_step(0, ena_d, raw_d, 1);
      model_step(1, ena_p, raw_p, 4);
    end
  end

  always @(negedge clk) begin
    check("m_clean0", clean_d, m_clean[0]);
    check("m_rise0",  rise_d,  m_rise[0]);
    check("m_fall0",  fall_d,  m_fall[0]);
    check("m_chg0",   {7'd0, chg_d}, {7'd0, |(m_rise[0] | m_fall[0])});
    check("m_clean1", clean_p, m_clean[1]);
    check("m_rise1",  rise_p,  m_rise[1]);
    check("m_fall1",  fall_p,  m_fall[1]);
    check("m_chg1",   {7'd0, chg_p}, {7'd0, |(m_rise[1] | m_fall[1])});
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int found;
  int pulses;

  initial begin
    rst = 1'b1; ena_d = 1'b1; ena_p = 1'b1; raw_d = 8'hFF; raw_p = 8'h00;

    // 1: reset holds everything at 0, then 6-edge debounce of 0xFF
    edge_n(3);
    check("rst_clean", clean_d, 8'h00);
    check("rst_rise",  rise_d,  8'h00);
    check("rst_chg",   {7'd0, chg_d}, 8'h00);
    @(negedge clk); rst = 1'b0;
    edge_n(5);
    check("t1_clean_e5", clean_d, 8'h00);
    edge_n(1);
    check("t1_clean_e6", clean_d, 8'hFF);
    check("t1_rise_e6",  rise_d,  8'hFF);
    check("t1_chg_e6",   {7'd0, chg_d}, 8'h01);
    edge_n(1);
    check("t1_rise_e7",  rise_d,  8'h00);
    check("t1_chg_e7",   {7'd0, chg_d}, 8'h00);

    // 2: a 3-cycle glitch on bit 0 is rejected
    @(negedge clk); raw_d = 8'h00;
    edge_n(10);
    check("t2_settle", clean_d, 8'h00);
    @(negedge clk); raw_d = 8'h01;
    repeat (3) @(negedge clk);
    raw_d = 8'h00;
    for (int i = 0; i < 12; i++) begin
      edge_n(1);
      check("t2_glitch_clean", clean_d, 8'h00);
      check("t2_glitch_rise",  rise_d,  8'h00);
    end

    // 3: fall pulse on the settled bits only
    @(negedge clk); raw_d = 8'h0F;
    edge_n(10);
    check("t3_settle", clean_d, 8'h0F);
    @(negedge clk); raw_d = 8'h00;
    edge_n(5);
    check("t3_clean_e5", clean_d, 8'h0F);
    edge_n(1);
    check("t3_fall_e6",  fall_d,  8'h0F);
    check("t3_clean_e6", clean_d, 8'h00);
    check("t3_rise_e6",  rise_d,  8'h00);

    // 4: PRESCALE=4 latency lands in 15..18 edges with a single rise pulse
    @(negedge clk); raw_p = 8'h80;
    found = 0; pulses = 0;
    for (int e = 1; e <= 30; e++) begin
      edge_n(1);
      if (clean_p[7] && found == 0) found = e;
      if (rise_p[7]) pulses++;
    end
    check("t4_latency_ok", {7'd0, (found >= 15 && found <= 18)}, 8'h01);
    if (!(found >= 15 && found <= 18)) $display("  t4 edge observed = %0d", found);
    check("t4_pulses", pulses[7:0], 8'h01);

    // 5: ena=0 after two counting ticks freezes the count
    @(negedge clk); raw_d = 8'h01;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    ena_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge_n(1);
      check("t5_frz_clean", clean_d, 8'h00);
      check("t5_frz_pulse", rise_d | fall_d, 8'h00);
    end
    @(negedge clk); ena_d = 1'b1;
    edge_n(1);
    check("t5_clean_t1", clean_d, 8'h00);
    edge_n(1);
    check("t5_clean_t2", clean_d, 8'h01);
    check("t5_rise_t2",  rise_d,  8'h01);

    // 6: asynchronous reset mid-count, then re-debounce from zero
    @(negedge clk); raw_d = 8'h03;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_async_clean", clean_d, 8'h00);
    check("t6_async_pulse", rise_d | fall_d, 8'h00);
    check("t6_async_chg",   {7'd0, chg_d}, 8'h00);
    #1 rst = 1'b0;
    edge_n(5);
    check("t6_clean_e5", clean_d, 8'h00);
    edge_n(1);
    check("t6_clean_e6", clean_d, 8'h03);
    check("t6_rise_e6",  rise_d,  8'h03);
    edge_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
